mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-ported unified memory between the instruction-fetch (I) and
//  data/MEM-stage (D) requesters of the 5-stage pipeline. Sequences each access as
//  a req/ack transaction, returns read data, and raises per-port stall so the
//  hazard/control logic can freeze IF or MEM. D wins by default; a streak limit
//  guarantees forward progress for I. Flushed fetches are drained and dropped.
// PARAMETERS
//  ADDR_W       32  address width, both ports and memory side
//  DATA_W       32  data width
//  MAX_D_STREAK 4   consecutive D grants allowed while I is pending before I is forced
// PORTS
//  clk        in   1       single clock, all state on rising edge
//  rst        in   1       asynchronous, active-high reset
//  if_req     in   1       I requests a read; held with if_addr until if_ack or if_flush
//  if_addr    in   ADDR_W  fetch address
//  if_flush   in   1       squash current/pending fetch (branch taken, cancel of next)
//  if_rdata   out  DATA_W  fetched word, valid when if_ack
//  if_ack     out  1       1-cycle pulse: fetch complete
//  stall_if   out  1       if_req & ~if_ack & ~if_flush
//  d_req      in   1       D requests access; held with d_we/d_addr/d_wdata until d_ack
//  d_we       in   1       1 = store, 0 = load
//  d_addr     in   ADDR_W  data address
//  d_wdata    in   DATA_W  store data
//  d_rdata    out  DATA_W  load data, valid when d_ack
//  d_ack      out  1       1-cycle pulse: access complete
//  stall_mem  out  1       d_req & ~d_ack
//  mem_req    out  1       memory request, held until mem_ack sampled
//  mem_we     out  1       memory write enable
//  mem_addr   out  ADDR_W  memory address
//  mem_wdata  out  DATA_W  memory write data
//  mem_rdata  in   DATA_W  memory read data, valid with mem_ack
//  mem_ack    in   1       memory completes transaction this cycle
// BEHAVIOUR
//  - Reset (async, any state): state=IDLE; mem_req/mem_we/if_ack/d_ack=0; all data/addr
//    regs=0; streak=0. Abandoned in-flight access is not replayed; memory tolerates drop.
//  - FSM: IDLE, DACC, IACC, IDROP. mem_* are registered, stable while mem_req=1.
//  - IDLE arbitration (one decision/cycle): force_i = (streak==MAX_D_STREAK) & if_req & ~if_flush.
//    force_i -> IACC; else d_req -> DACC; else if_req & ~if_flush -> IACC; else stay.
//    Grant latches addr/we/wdata into mem_* and sets mem_req next cycle.
//  - DACC: on mem_ack -> d_ack=1 next cycle, d_rdata<=mem_rdata if ~mem_we (unchanged on
//    store), mem_req=0, -> IDLE. if_flush has no effect here.
//  - IACC: on mem_ack -> if_ack=1, if_rdata<=mem_rdata, -> IDLE. if_flush (without same-cycle
//    mem_ack) -> IDROP. if_flush with mem_ack same cycle -> no if_ack, -> IDLE.
//  - IDROP: mem_req held; on mem_ack -> no ack, data discarded, -> IDLE.
//  - Latency: request seen cycle t, mem_req at t+1, mem_ack at t+1+k (k>=0), ack at t+2+k.
//    One IDLE turnaround cycle between transactions; ack pulse and next grant decision coincide.
//  - Streak: +1 on each D grant while if_req=1 (saturates at MAX_D_STREAK); cleared on any I
//    grant or when if_req=0.
//  - mem_ack while IDLE: ignored. Requester dropping req after grant: transaction still
//    completes and acks (D) / drops only if if_flush (I).
//  - if_ack and d_ack never both 1 in the same cycle.
// STRUCTURE
//  - Shared include: state encodings (ARB_IDLE/ARB_DACC/ARB_IACC/ARB_IDROP), default widths.
//  - Single module; streak counter is inline (no sub-module needed).
// TESTING
//  1 Reset mid-DACC: rst at cycle 3 -> mem_req=0, d_ack=0 same cycle, state IDLE, streak=0.
//  2 Lone load: d_req,d_we=0,d_addr=0x40; mem acks k=2 with 0xDEADBEEF -> d_ack at t+4,
//    d_rdata=0xDEADBEEF, stall_mem=1 for cycles t..t+3.
//  3 Simultaneous if_req(0x100)+d_req(0x200): D granted first, I granted after D ack+1 IDLE;
//    if_rdata correct, never both acks same cycle.
//  4 Starvation, MAX_D_STREAK=4: continuous d_req + if_req -> exactly 4 D grants then 1 I grant.
//  5 Flush: if_flush during IACC, mem_ack 2 cycles later -> no if_ack, state IDROP->IDLE,
//    if_rdata unchanged; flush same cycle as mem_ack -> no if_ack.
//  6 Store: d_we=1, d_wdata=0x12345678 -> mem_we=1, mem_wdata stable until ack, d_rdata unchanged.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the unified-memory port arbiter: state encoding,
// default widths and the streak-counter width helper.
package mem_port_arbiter_pkg;

    localparam int ADDR_W_DEF       = 32;
    localparam int DATA_W_DEF       = 32;
    localparam int MAX_D_STREAK_DEF = 4;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_DACC  = 2'd1,
        ARB_IACC  = 2'd2,
        ARB_IDROP = 2'd3
    } arb_state_t;

    // Bits needed to hold 0..max_streak inclusive, never less than one.
    function automatic int streak_width(input int max_streak);
        return (max_streak < 1) ? 1 : $clog2(max_streak + 1);
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-ported unified memory between instruction fetch (I) and
// the MEM stage (D). D has priority; a D-grant streak limit forces I through.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int MAX_D_STREAK = MAX_D_STREAK_DEF
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              if_flush,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ack,
    output logic              stall_if,

    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_ack,
    output logic              stall_mem,

    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ack
);

    localparam int                  STREAK_W   = streak_width(MAX_D_STREAK);
    localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(MAX_D_STREAK);

    arb_state_t          state_reg;
    logic [STREAK_W-1:0] streak_reg;
    logic [STREAK_W-1:0] streak_next;

    logic                mem_req_reg;
    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_addr_reg;
    logic [DATA_W-1:0]   mem_wdata_reg;
    logic [DATA_W-1:0]   if_rdata_reg;
    logic [DATA_W-1:0]   d_rdata_reg;
    logic                if_ack_reg;
    logic                d_ack_reg;

    logic                if_live;
    logic                force_i;
    logic                grant_d;
    logic                grant_i;

    // A fetch being flushed this cycle is not a candidate for a grant.
    assign if_live = if_req & ~if_flush;
    assign force_i = (streak_reg == STREAK_MAX) & if_live;
    assign grant_d = (state_reg == ARB_IDLE) & ~force_i & d_req;
    assign grant_i = (state_reg == ARB_IDLE) & (force_i | (~d_req & if_live));

    // Counts back-to-back D wins only while I is actually waiting.
    always_comb begin
        streak_next = streak_reg;
        if (!if_req || grant_i) begin
            streak_next = '0;
        end else if (grant_d && (streak_reg != STREAK_MAX)) begin
            streak_next = streak_reg + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= ARB_IDLE;
            streak_reg    <= '0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            if_rdata_reg  <= '0;
            d_rdata_reg   <= '0;
            if_ack_reg    <= 1'b0;
            d_ack_reg     <= 1'b0;
        end else begin
            if_ack_reg <= 1'b0;
            d_ack_reg  <= 1'b0;
            streak_reg <= streak_next;

            case (state_reg)
                ARB_IDLE: begin
                    if (grant_d) begin
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= d_we;
                        mem_addr_reg  <= d_addr;
                        mem_wdata_reg <= d_wdata;
                        state_reg     <= ARB_DACC;
                    end else if (grant_i) begin
                        mem_req_reg  <= 1'b1;
                        mem_we_reg   <= 1'b0;
                        mem_addr_reg <= if_addr;
                        state_reg    <= ARB_IACC;
                    end
                end

                ARB_DACC: begin
                    if (mem_ack) begin
                        d_ack_reg <= 1'b1;
                        if (!mem_we_reg) begin
                            d_rdata_reg <= mem_rdata;
                        end
                        mem_req_reg <= 1'b0;
                        mem_we_reg  <= 1'b0;
                        state_reg   <= ARB_IDLE;
                    end
                end

                ARB_IACC: begin
                    if (mem_ack) begin
                        // A flush landing with the completion still suppresses the ack.
                        if (!if_flush) begin
                            if_ack_reg   <= 1'b1;
                            if_rdata_reg <= mem_rdata;
                        end
                        mem_req_reg <= 1'b0;
                        state_reg   <= ARB_IDLE;
                    end else if (if_flush) begin
                        state_reg <= ARB_IDROP;
                    end
                end

                ARB_IDROP: begin
                    if (mem_ack) begin
                        mem_req_reg <= 1'b0;
                        state_reg   <= ARB_IDLE;
                    end
                end

                default: state_reg <= ARB_IDLE;
            endcase
        end
    end

    assign mem_req   = mem_req_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign if_rdata  = if_rdata_reg;
    assign d_rdata   = d_rdata_reg;
    assign if_ack    = if_ack_reg;
    assign d_ack     = d_ack_reg;
    assign stall_if  = if_req & ~if_ack_reg & ~if_flush;
    assign stall_mem = d_req & ~d_ack_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios plus randomized
// concurrent I/D traffic against a simple reference memory model.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXS = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          if_req = 1'b0, if_flush = 1'b0, if_ack, stall_if;
    logic [AW-1:0] if_addr = '0;
    logic [DW-1:0] if_rdata;
    logic          d_req = 1'b0, d_we = 1'b0, d_ack, stall_mem;
    logic [AW-1:0] d_addr = '0;
    logic [DW-1:0] d_wdata = '0, d_rdata;
    logic          mem_req, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ack = 1'b0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_D_STREAK(MAXS)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_rdata(if_rdata), .if_ack(if_ack), .stall_if(stall_if),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_ack(d_ack), .stall_mem(stall_mem),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int d_ack_total = 0, i_ack_total = 0;
    int d_ack_cyc = 0, i_ack_cyc = 0;

    logic [DW-1:0] phys_mem [logic [AW-1:0]];
    logic [DW-1:0] ref_mem  [logic [AW-1:0]];
    logic [DW-1:0] d_exp_q[$];
    logic [DW-1:0] i_exp_q[$];
    logic [DW-1:0] exp_last_load = '0;

    int            mem_k_min = 0, mem_k_max = 0;
    bit            busy = 0;
    int            wcnt = 0;
    logic [AW-1:0] cap_addr = '0;
    logic [DW-1:0] cap_wdata = '0;
    logic          cap_we = 1'b0;

    function automatic logic [DW-1:0] init_word(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endfunction

    function automatic logic [DW-1:0] rd_phys(input logic [AW-1:0] a);
        return phys_mem.exists(a) ? phys_mem[a] : init_word(a);
    endfunction

    function automatic logic [DW-1:0] rd_ref(input logic [AW-1:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got event expected none (t=%0t)", name, $time);
    endtask

    task automatic sync();
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Memory model: random-latency responder, checks request stability.
    initial forever begin
        @(posedge clk);
        #1;
        if (rst) begin
            busy    = 0;
            mem_ack = 1'b0;
        end else if (mem_ack) begin
            mem_ack = 1'b0;
            busy    = 0;
        end else if (mem_req) begin
            if (!busy) begin
                busy      = 1;
                wcnt      = $urandom_range(mem_k_max, mem_k_min);
                cap_addr  = mem_addr;
                cap_wdata = mem_wdata;
                cap_we    = mem_we;
            end else begin
                check("mem_addr_stable", mem_addr, cap_addr);
                check("mem_wdata_stable", mem_wdata, cap_wdata);
                check_bit("mem_we_stable", mem_we, cap_we);
            end
            if (wcnt == 0) begin
                mem_ack   = 1'b1;
                mem_rdata = rd_phys(mem_addr);
                if (mem_we) phys_mem[mem_addr] = mem_wdata;
            end else begin
                wcnt--;
                mem_rdata = $urandom;
            end
        end else begin
            mem_rdata = $urandom;
        end
    end

    // Monitor: pops the scoreboard on every ack pulse.
    initial forever begin : monitor
        logic [DW-1:0] e;
        @(negedge clk);
        if (!rst) begin
            check_bit("stall_if", stall_if, if_req & ~if_ack & ~if_flush);
            check_bit("stall_mem", stall_mem, d_req & ~d_ack);
            if (if_ack && d_ack) fail_now("dual_ack");
            if (d_ack) begin
                d_ack_total++;
                if (d_exp_q.size() == 0) fail_now("d_ack_unexpected");
                else begin
                    e = d_exp_q.pop_front();
                    check("d_rdata", d_rdata, e);
                end
                $display("[%0d] D ack rdata=%h", cyc, d_rdata);
            end
            if (if_ack) begin
                i_ack_total++;
                if (i_exp_q.size() == 0) fail_now("if_ack_unexpected");
                else begin
                    e = i_exp_q.pop_front();
                    check("if_rdata", if_rdata, e);
                end
                $display("[%0d] I ack rdata=%h", cyc, if_rdata);
            end
        end
    end

    task automatic d_issue(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
        int n;
        if (we) ref_mem[addr] = wdata;
        else exp_last_load = rd_ref(addr);
        d_exp_q.push_back(exp_last_load);
        d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
        n = 0;
        do begin
            sync();
            n++;
        end while (!d_ack && n < 200);
        if (!d_ack) fail_now("d_timeout");
        d_ack_cyc = cyc;
        d_req = 1'b0;
        d_we  = 1'b0;
    endtask

    task automatic i_fetch(input logic [AW-1:0] addr, input int flush_at);
        int n;
        bit flushed;
        i_exp_q.push_back(init_word(addr));
        if_req = 1'b1; if_addr = addr;
        n = 0; flushed = 0;
        do begin
            sync();
            n++;
            if (!if_ack && n == flush_at) begin
                flushed = 1;
                i_exp_q.delete(i_exp_q.size() - 1);
                $display("[%0d] I flush addr=%h", cyc, addr);
                if_flush = 1'b1;
                sync();
                if_flush = 1'b0;
            end
        end while (!if_ack && !flushed && n < 200);
        if (!if_ack && !flushed) fail_now("i_timeout");
        i_ack_cyc = cyc;
        if_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n, quiet;
        n = 0; quiet = 0;
        while (quiet < 2 && n < 300) begin
            sync();
            n++;
            quiet = (!mem_req && !busy) ? quiet + 1 : 0;
        end
        if (quiet < 2) fail_now("idle_timeout");
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, cnt, start, i_seen, i0;
        logic [DW-1:0] prev;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check_bit("rst_mem_req", mem_req, 1'b0);
        check_bit("rst_mem_we", mem_we, 1'b0);
        check("rst_mem_addr", mem_addr, 32'h0);
        check_bit("rst_if_ack", if_ack, 1'b0);
        check_bit("rst_d_ack", d_ack, 1'b0);
        check("rst_d_rdata", d_rdata, 32'h0);
        check("rst_if_rdata", if_rdata, 32'h0);

        // Reset in the middle of a D access.
        mem_k_min = 6; mem_k_max = 6;
        d_req = 1'b1; d_addr = 32'h80;
        sync();
        check_bit("grant_mem_req", mem_req, 1'b1);
        check("grant_mem_addr", mem_addr, 32'h80);
        sync();
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_bit("midrst_mem_req", mem_req, 1'b0);
        check_bit("midrst_d_ack", d_ack, 1'b0);
        check("midrst_mem_addr", mem_addr, 32'h0);
        d_req = 1'b0; d_addr = '0;
        sync();
        rst = 1'b0;
        exp_last_load = '0;
        sync();

        // A stray mem_ack while idle must be ignored.
        mem_ack = 1'b1; mem_rdata = 32'hBAD0BAD0;
        sync();
        sync();
        check_bit("stray_ack_no_req", mem_req, 1'b0);
        check_bit("stray_ack_no_dack", d_ack, 1'b0);
        check_bit("stray_ack_no_iack", if_ack, 1'b0);

        // Lone load, memory latency 2.
        mem_k_min = 2; mem_k_max = 2;
        phys_mem[32'h40] = 32'hDEADBEEF;
        ref_mem[32'h40]  = 32'hDEADBEEF;
        t0 = cyc; cnt = 0;
        fork
            d_issue(1'b0, 32'h40, '0);
            begin
                repeat (6) begin
                    @(negedge clk);
                    if (stall_mem) cnt++;
                end
            end
        join
        check("load_latency", d_ack_cyc - t0, 4);
        check("stall_mem_cycles", cnt, 4);
        check("lone_load_rdata", d_rdata, 32'hDEADBEEF);
        sync();

        // Simultaneous I and D requests: D first, I one turnaround later.
        mem_k_min = 0; mem_k_max = 0;
        fork
            d_issue(1'b0, 32'h200, '0);
            i_fetch(32'h100, -1);
        join
        check("i_after_d_gap", i_ack_cyc - d_ack_cyc, 2);
        check("simul_if_rdata", if_rdata, init_word(32'h100));
        sync();

        // Streak limit: continuous D traffic with a pending fetch.
        start = d_ack_total; i_seen = -1;
        fork
            begin
                repeat (6) d_issue(1'b0, 32'h200 + 32'(4 * $urandom_range(0, 7)), '0);
            end
            begin
                i_fetch(32'h104, -1);
                i_seen = d_ack_total - start;
            end
        join
        check("d_grants_before_forced_i", i_seen, MAXS);
        sync();

        // Flush while the fetch is outstanding, then flush coinciding with mem_ack.
        mem_k_min = 4; mem_k_max = 4;
        prev = if_rdata; i0 = i_ack_total;
        i_fetch(32'h1100, 2);
        wait_idle();
        check("flush_no_ack", i_ack_total - i0, 0);
        check("flush_rdata_kept", if_rdata, prev);
        check_bit("idrop_drained", mem_req, 1'b0);
        mem_k_min = 2; mem_k_max = 2;
        i0 = i_ack_total;
        i_fetch(32'h1104, 3);
        wait_idle();
        check("flush_at_ack_no_ack", i_ack_total - i0, 0);
        check("flush_at_ack_rdata_kept", if_rdata, prev);
        i_fetch(32'h1108, -1);
        check("post_flush_fetch", if_rdata, init_word(32'h1108));
        sync();

        // Store then load back.
        mem_k_min = 1; mem_k_max = 1;
        prev = d_rdata;
        d_issue(1'b1, 32'h44, 32'h12345678);
        check_bit("store_mem_we", cap_we, 1'b1);
        check("store_mem_wdata", cap_wdata, 32'h12345678);
        check("store_mem_addr", cap_addr, 32'h44);
        check("store_d_rdata_kept", d_rdata, prev);
        d_issue(1'b0, 32'h44, '0);
        check("load_after_store", d_rdata, 32'h12345678);
        sync();

        // Randomized concurrent traffic.
        mem_k_min = 0; mem_k_max = 3;
        fork
            begin
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 2)) sync();
                    d_issue(1'($urandom_range(0, 1)), 32'h200 + 32'(4 * $urandom_range(0, 7)), $urandom);
                end
            end
            begin
                for (int i = 0; i < 50; i++) begin
                    repeat ($urandom_range(0, 2)) sync();
                    i_fetch(32'h1000 + 32'(4 * $urandom_range(0, 15)),
                            ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 6)) : -1);
                end
            end
        join
        wait_idle();
        repeat (3) sync();
        check("d_queue_drained", d_exp_q.size(), 0);
        check("i_queue_drained", i_exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
